// File: rtl/ula4_arb_if.sv
// Bundle of requester, datapath and status signals around the shared ula4 arbiter.
// The arbiter connects to the slave view and the surrounding logic to the master view.
interface ula4_arb_if #(
    parameter int W   = 4,
    parameter int OPW = 4
) ();
    logic           req0, req1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic [OPW-1:0] op0, op1;
    logic           ack0, ack1;
    logic           res_valid0, res_valid1;
    logic [W-1:0]   res0, res1;
    logic           ov0, ov1;
    logic           res_ready0, res_ready1;
    logic [W-1:0]   alu_a, alu_b, alu_out;
    logic [OPW-1:0] alu_op;
    logic           alu_ov;
    logic           busy, err_timeout;

    modport slave (
        input  req0, a0, b0, op0, res_ready0,
        input  req1, a1, b1, op1, res_ready1,
        input  alu_out, alu_ov,
        output ack0, res_valid0, res0, ov0,
        output ack1, res_valid1, res1, ov1,
        output alu_a, alu_b, alu_op, busy, err_timeout
    );

    modport master (
        output req0, a0, b0, op0, res_ready0,
        output req1, a1, b1, op1, res_ready1,
        output alu_out, alu_ov,
        input  ack0, res_valid0, res0, ov0,
        input  ack1, res_valid1, res1, ov1,
        input  alu_a, alu_b, alu_op, busy, err_timeout
    );
endinterface

// File: rtl/ula4_arb.sv
// Round-robin arbiter/sequencer sharing one ula4 between two requesters:
// IDLE grants and latches operands, EXEC lets ula4 settle, RESP hands the result back.
module ula4_arb #(
    parameter int W            = 4,
    parameter int OPW          = 4,
    parameter int RESP_TIMEOUT = 15
) (
    input logic       clk,
    input logic       rst,
    ula4_arb_if.slave bus
);
    localparam int CW = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = (RESP_TIMEOUT == 0) ? '0 : CW'(RESP_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_reg, state_next;
    logic [1:0]     req, res_ready, ack, capture, drop;
    logic [W-1:0]   a_in [2];
    logic [W-1:0]   b_in [2];
    logic [OPW-1:0] op_in [2];
    logic           pick;
    logic           grant_reg, grant_next;
    logic           last_grant_reg, last_grant_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [W-1:0]   alu_a_reg, alu_a_next, alu_b_reg, alu_b_next;
    logic [OPW-1:0] alu_op_reg, alu_op_next;
    logic           err_reg, err_next;

    assign req       = {bus.req1, bus.req0};
    assign res_ready = {bus.res_ready1, bus.res_ready0};
    assign a_in[0]   = bus.a0;
    assign a_in[1]   = bus.a1;
    assign b_in[0]   = bus.b0;
    assign b_in[1]   = bus.b1;
    assign op_in[0]  = bus.op0;
    assign op_in[1]  = bus.op1;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign pick = req[1] & (~req[0] | ~last_grant_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            cnt_reg        <= '0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_op_reg     <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            cnt_reg        <= cnt_next;
            alu_a_reg      <= alu_a_next;
            alu_b_reg      <= alu_b_next;
            alu_op_reg     <= alu_op_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        cnt_next        = cnt_reg;
        alu_a_next      = alu_a_reg;
        alu_b_next      = alu_b_reg;
        alu_op_next     = alu_op_reg;
        err_next        = 1'b0;
        ack             = '0;
        capture         = '0;
        drop            = '0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    ack[pick]   = 1'b1;
                    grant_next  = pick;
                    alu_a_next  = a_in[pick];
                    alu_b_next  = b_in[pick];
                    alu_op_next = op_in[pick];
                    state_next  = EXEC;
                end
            end
            EXEC: begin
                capture[grant_reg] = 1'b1;
                cnt_next           = '0;
                state_next         = RESP;
            end
            RESP: begin
                if (res_ready[grant_reg]) begin
                    drop[grant_reg] = 1'b1;
                    last_grant_next = grant_reg;
                    state_next      = IDLE;
                end else if ((RESP_TIMEOUT != 0) && (cnt_reg == TO_LAST)) begin
                    drop[grant_reg] = 1'b1;
                    err_next        = 1'b1;
                    last_grant_next = grant_reg;
                    state_next      = IDLE;
                end else if (RESP_TIMEOUT != 0) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // ack is combinational, so it must be masked while reset forces outputs low.
        if (rst) ack = '0;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [W-1:0] res_reg;
        logic         ov_reg, valid_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                res_reg   <= '0;
                ov_reg    <= 1'b0;
                valid_reg <= 1'b0;
            end else if (capture[gi]) begin
                res_reg   <= bus.alu_out;
                ov_reg    <= bus.alu_ov;
                valid_reg <= 1'b1;
            end else if (drop[gi]) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign bus.ack0        = ack[0];
    assign bus.ack1        = ack[1];
    assign bus.res0        = g_port[0].res_reg;
    assign bus.ov0         = g_port[0].ov_reg;
    assign bus.res_valid0  = g_port[0].valid_reg;
    assign bus.res1        = g_port[1].res_reg;
    assign bus.ov1         = g_port[1].ov_reg;
    assign bus.res_valid1  = g_port[1].valid_reg;
    assign bus.alu_a       = alu_a_reg;
    assign bus.alu_b       = alu_b_reg;
    assign bus.alu_op      = alu_op_reg;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.err_timeout = err_reg;
endmodule
